// File: rtl/match_lock_detector_pkg.sv
// Shared types and constants for the match lock detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   lock_state_e : detector FSM states (SEARCH, LOCKED)
//   STAT_W       : width of the optional running match/miss totals
package match_lock_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam int STAT_W = 16;

endpackage : match_lock_pkg

// File: rtl/match_lock_detector_comparator_3bit.sv
// 3-bit equality comparator feeding the lock detector.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the inputs continuously.
//
// Ports:
//   a, b : operands
//   eq   : 1 when a == b
module comparator_3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       eq
);

  assign eq = (a == b);

endmodule : comparator_3bit

// File: rtl/match_lock_detector.sv
// Hysteretic lock detector over a stream of 3-bit operand-pair comparisons.
// Latency: 1 cycle from an accepted sample to eq_q/streak/locked/pulses.
// Backpressure: none; every edge with in_valid=1 consumes a sample.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : synchronous soft clear of FSM, counters and eq_q (wins over in_valid)
//   in_valid       : sample qualifier
//   in_a, in_b     : operand pair
//   eq_q           : registered equality of the last accepted sample
//   streak         : consecutive-match count, saturating at 2^CNT_W-1
//   locked         : 1 while in LOCKED
//   lock_pulse     : one cycle after SEARCH->LOCKED
//   unlock_pulse   : one cycle after LOCKED->SEARCH
//   match_total,
//   miss_total     : saturating running totals, present only with MATCH_LOCK_STATS_EN
//                    defined; reset by rst_n only, untouched by clear
module match_lock_detector
  import match_lock_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [2:0]       in_a,
  input  logic [2:0]       in_b,
  output logic             eq_q,
  output logic [CNT_W-1:0] streak,
  output logic             locked,
  output logic             lock_pulse,
  output logic             unlock_pulse
`ifdef MATCH_LOCK_STATS_EN
  ,
  output logic [STAT_W-1:0] match_total,
  output logic [STAT_W-1:0] miss_total
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] LOCK_THR   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_THR = CNT_W'(UNLOCK_COUNT);

  logic eq;

  comparator_3bit u_cmp (
    .a  (in_a),
    .b  (in_b),
    .eq (eq)
  );

  lock_state_e      state_q, state_n;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_n;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_n;
  logic             eq_n;
  logic             lock_pulse_n, unlock_pulse_n;
  logic [CNT_W-1:0] match_inc, miss_inc;

  // match_cnt saturates instead of wrapping; miss_cnt is bounded by the
  // unlock threshold (it resets to 0 when it reaches it), so a plain add is safe.
  assign match_inc = (match_cnt_q == CNT_MAX) ? match_cnt_q : match_cnt_q + 1'b1;
  assign miss_inc  = miss_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      eq_q         <= 1'b0;
      lock_pulse   <= 1'b0;
      unlock_pulse <= 1'b0;
    end else begin
      state_q      <= state_n;
      match_cnt_q  <= match_cnt_n;
      miss_cnt_q   <= miss_cnt_n;
      eq_q         <= eq_n;
      lock_pulse   <= lock_pulse_n;
      unlock_pulse <= unlock_pulse_n;
    end
  end

  always_comb begin
    state_n        = state_q;
    match_cnt_n    = match_cnt_q;
    miss_cnt_n     = miss_cnt_q;
    eq_n           = eq_q;
    lock_pulse_n   = 1'b0;
    unlock_pulse_n = 1'b0;

    if (clear) begin
      // Soft clear silently drops lock: no unlock pulse even from LOCKED.
      state_n     = SEARCH;
      match_cnt_n = '0;
      miss_cnt_n  = '0;
      eq_n        = 1'b0;
    end else if (in_valid) begin
      eq_n = eq;
      unique case (state_q)
        SEARCH: begin
          if (eq) begin
            match_cnt_n = match_inc;
            if (match_inc == LOCK_THR) begin
              state_n      = LOCKED;
              lock_pulse_n = 1'b1;
              miss_cnt_n   = '0;
            end
          end else begin
            match_cnt_n = '0;
          end
        end
        LOCKED: begin
          if (eq) begin
            match_cnt_n = match_inc;
            miss_cnt_n  = '0;
          end else begin
            match_cnt_n = '0;
            miss_cnt_n  = miss_inc;
            if (miss_inc == UNLOCK_THR) begin
              state_n        = SEARCH;
              unlock_pulse_n = 1'b1;
              miss_cnt_n     = '0;
            end
          end
        end
        default: begin
          state_n = SEARCH;
        end
      endcase
    end
  end

  assign streak = match_cnt_q;
  assign locked = (state_q == LOCKED);

`ifdef MATCH_LOCK_STATS_EN
  logic [STAT_W-1:0] match_total_q, miss_total_q;

  // A sample arriving with clear is overridden by the clear, so it is not
  // counted as accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_total_q <= '0;
      miss_total_q  <= '0;
    end else if (in_valid && !clear) begin
      if (eq) begin
        if (match_total_q != '1) match_total_q <= match_total_q + 1'b1;
      end else begin
        if (miss_total_q != '1) miss_total_q <= miss_total_q + 1'b1;
      end
    end
  end

  assign match_total = match_total_q;
  assign miss_total  = miss_total_q;
`endif

endmodule : match_lock_detector

// File: tb/tb_match_lock_detector.sv
// Directed self-checking bench for match_lock_detector (default parameters).
// Inputs change on the falling edge; outputs are sampled on the next falling edge.
// Covers MATCH_LOCK_STATS_EN when that macro is defined for the build.
module tb_match_lock_detector;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [2:0] in_a;
  logic [2:0] in_b;
  logic       eq_q;
  logic [3:0] streak;
  logic       locked;
  logic       lock_pulse;
  logic       unlock_pulse;
`ifdef MATCH_LOCK_STATS_EN
  logic [15:0] match_total;
  logic [15:0] miss_total;
`endif

  int n_cmp = 0;
  int n_err = 0;

  match_lock_detector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_a         (in_a),
    .in_b         (in_b),
    .eq_q         (eq_q),
    .streak       (streak),
    .locked       (locked),
    .lock_pulse   (lock_pulse),
    .unlock_pulse (unlock_pulse)
`ifdef MATCH_LOCK_STATS_EN
    ,
    .match_total  (match_total),
    .miss_total   (miss_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid) begin
      assert (!$isunknown({in_a, in_b}))
        else $error("FAIL x_operands: in_a=%b in_b=%b while in_valid", in_a, in_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs (called on a falling edge) and return on the
  // next falling edge, after the rising edge has taken effect.
  task automatic cyc(input logic v, input logic [2:0] a, input logic [2:0] b, input logic c);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    clear    = c;
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  // Unlock scenario from LOCKED: miss, miss, match, miss, miss, miss.
  logic [2:0] t2_a      [6] = '{3'd3, 3'd3, 3'd3, 3'd1, 3'd1, 3'd1};
  logic [2:0] t2_b      [6] = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd2, 3'd2};
  logic [3:0] t2_streak [6] = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
  logic       t2_eq     [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       t2_locked [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       t2_unl    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_a     = 3'd0;
    in_b     = 3'd0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_eq_q", 32'(eq_q), 0);
    chk("rst_streak", 32'(streak), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_lock_pulse", 32'(lock_pulse), 0);
    chk("rst_unlock_pulse", 32'(unlock_pulse), 0);
`ifdef MATCH_LOCK_STATS_EN
    chk("rst_match_total", 32'(match_total), 0);
    chk("rst_miss_total", 32'(miss_total), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Four matches lock the detector on the fourth.
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 3'd5, 3'd5, 1'b0);
      chk($sformatf("lock_streak_%0d", i), 32'(streak), 32'(i));
      chk($sformatf("lock_eq_%0d", i), 32'(eq_q), 1);
      chk($sformatf("lock_pulse_%0d", i), 32'(lock_pulse), (i == 4) ? 1 : 0);
      chk($sformatf("lock_locked_%0d", i), 32'(locked), (i == 4) ? 1 : 0);
    end
    cyc(1'b0, 3'd5, 3'd5, 1'b0);
    chk("lock_pulse_drop", 32'(lock_pulse), 0);
    chk("lock_hold_locked", 32'(locked), 1);
    chk("lock_hold_streak", 32'(streak), 4);

    // Two-miss gap does not unlock; three consecutive misses do.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, t2_a[i], t2_b[i], 1'b0);
      chk($sformatf("unl_streak_%0d", i), 32'(streak), 32'(t2_streak[i]));
      chk($sformatf("unl_eq_%0d", i), 32'(eq_q), 32'(t2_eq[i]));
      chk($sformatf("unl_locked_%0d", i), 32'(locked), 32'(t2_locked[i]));
      chk($sformatf("unl_pulse_%0d", i), 32'(unlock_pulse), 32'(t2_unl[i]));
    end
    cyc(1'b0, 3'd0, 3'd0, 1'b0);
    chk("unl_pulse_drop", 32'(unlock_pulse), 0);
    chk("unl_hold_locked", 32'(locked), 0);

    // Twenty matches: streak saturates at 15, lock on the fourth.
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 3'd6, 3'd6, 1'b0);
      chk($sformatf("sat_streak_%0d", i), 32'(streak), (i > 15) ? 15 : 32'(i));
      chk($sformatf("sat_lock_pulse_%0d", i), 32'(lock_pulse), (i == 4) ? 1 : 0);
    end
    chk("sat_locked", 32'(locked), 1);
`ifdef MATCH_LOCK_STATS_EN
    chk("stats_match_total", 32'(match_total), 25);
    chk("stats_miss_total", 32'(miss_total), 5);
`endif

    // Clear with a valid match while LOCKED.
    cyc(1'b1, 3'd5, 3'd5, 1'b1);
    chk("clr_locked", 32'(locked), 0);
    chk("clr_streak", 32'(streak), 0);
    chk("clr_eq_q", 32'(eq_q), 0);
    chk("clr_lock_pulse", 32'(lock_pulse), 0);
    chk("clr_unlock_pulse", 32'(unlock_pulse), 0);

    // Hold across an in_valid=0 gap at streak 2.
    cyc(1'b1, 3'd2, 3'd2, 1'b0);
    cyc(1'b1, 3'd7, 3'd7, 1'b0);
    chk("gap_pre_streak", 32'(streak), 2);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 3'd1, 3'd2, 1'b0);
      chk($sformatf("gap_streak_%0d", i), 32'(streak), 2);
      chk($sformatf("gap_eq_%0d", i), 32'(eq_q), 1);
      chk($sformatf("gap_locked_%0d", i), 32'(locked), 0);
    end
    cyc(1'b1, 3'd0, 3'd0, 1'b0);
    chk("gap_post_streak", 32'(streak), 3);
    chk("gap_post_locked", 32'(locked), 0);
    cyc(1'b1, 3'd0, 3'd0, 1'b0);
    chk("gap_lock_pulse", 32'(lock_pulse), 1);
    chk("gap_locked", 32'(locked), 1);

    // Asynchronous reset between edges while LOCKED.
    cyc(1'b1, 3'd4, 3'd4, 1'b0);
    chk("arst_pre_locked", 32'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_eq_q", 32'(eq_q), 0);
    chk("arst_streak", 32'(streak), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_lock_pulse", 32'(lock_pulse), 0);
    chk("arst_unlock_pulse", 32'(unlock_pulse), 0);
`ifdef MATCH_LOCK_STATS_EN
    chk("arst_match_total", 32'(match_total), 0);
    chk("arst_miss_total", 32'(miss_total), 0);
`endif

    // First sample after reset counts from zero.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 3'd3, 3'd3, 1'b0);
    chk("post_rst_streak", 32'(streak), 1);
    chk("post_rst_locked", 32'(locked), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_match_lock_detector

// File: doc/match_lock_detector.md
# match_lock_detector

Sequential consumer of the 3-bit equality result produced by `comparator_3bit`. It accepts a stream of valid-qualified 3-bit operand pairs and compares each pair through an internal `comparator_3bit` instance. It tracks consecutive matches and mismatches and drives a hysteretic `locked` flag with one-cycle lock/unlock event pulses. It sits directly downstream of the comparator in the pattern-alignment path.

## Interface
- `LOCK_COUNT`, 4, consecutive valid matches needed to enter LOCKED; legal 1..2^CNT_W-1
- `UNLOCK_COUNT`, 3, consecutive valid mismatches while LOCKED needed to return to SEARCH; legal 1..2^CNT_W-1
- `CNT_W`, 4, width of the streak counters
- `clk`  input  1  single clock; all state updates on the rising edge
- `rst_n`  input  1  reset, asynchronous, active-low
- `clear`  input  1  synchronous soft clear of state and counters
- `in_valid`  input  1  sample qualifier; no backpressure, a sample is consumed on every edge with `in_valid`=1
- `in_a`  input  3  operand A
- `in_b`  input  3  operand B
- `eq_q`  output  1  registered EQ of the last accepted sample
- `streak`  output  CNT_W  current consecutive-match count, saturating
- `locked`  output  1  1 while in LOCKED
- `lock_pulse`  output  1  one-cycle pulse on the SEARCH->LOCKED transition
- `unlock_pulse`  output  1  one-cycle pulse on the LOCKED->SEARCH transition

## Operation
- EQ is computed combinationally by `comparator_3bit` from `in_a`/`in_b`. It is used only on edges where `in_valid`=1.
- Internal counters: `match_cnt` (drives `streak`) and `miss_cnt`, both CNT_W bits.
- The FSM has two states, SEARCH and LOCKED. Reset state is SEARCH.
- SEARCH, valid match: `match_cnt` increments with saturation. If the new value equals LOCK_COUNT, go to LOCKED, assert `lock_pulse`, and set `miss_cnt` to 0.
- SEARCH, valid mismatch: `match_cnt` is set to 0.
- LOCKED, valid match: `match_cnt` increments with saturation and `miss_cnt` is set to 0.
- LOCKED, valid mismatch: `match_cnt` is set to 0 and `miss_cnt` increments. If the new value equals UNLOCK_COUNT, go to SEARCH, assert `unlock_pulse`, and set `miss_cnt` to 0.
- `in_valid`=0: all state, counters and `eq_q` hold. Pulses are 0.
- `clear`=1 has priority over `in_valid`. It forces SEARCH, both counters to 0 and `eq_q` to 0, with no pulse, even when leaving LOCKED.
- Saturation: `match_cnt` stops at 2^CNT_W-1 and never wraps. `miss_cnt` cannot exceed UNLOCK_COUNT.
- LOCK_COUNT=1: a single valid match in SEARCH locks immediately.
- `in_a`/`in_b` must be free of X/Z whenever `in_valid`=1. The bench asserts this.

## Timing
- Reset values of all outputs are 0: `eq_q`, `streak`, `locked`, `lock_pulse`, `unlock_pulse`, and stats when compiled in. State is SEARCH.
- Reset assertion takes effect immediately, independent of `clk`. Reset release is synchronised to `clk` by the upstream reset synchroniser.
- Latency is 1 cycle: a sample accepted at edge N is reflected in `eq_q`, `streak`, `locked` and the pulses after edge N.
- Each pulse is high for exactly the one cycle following the transition edge. A pulse is never high on two consecutive cycles.
- Reset mid-streak discards all progress. The first valid sample after reset is counted from zero.

## Configuration
- Macro: `MATCH_LOCK_STATS_EN`.
- With the macro defined, the block adds outputs `match_total` and `miss_total` (16 bits each).
  - They count accepted matches and mismatches, saturating at 16'hFFFF.
  - They are cleared only by `rst_n`; `clear` does not affect them.
- Without the macro, these ports and their counters are absent, and the remaining behaviour is identical.

## Structure
- Package `match_lock_pkg` holds:
  - `lock_state_e` enum typedef {SEARCH, LOCKED}
  - constant `STAT_W` = 16
- Sub-module: one `comparator_3bit` instance supplies EQ. No other hierarchy.

## Test plan
- Reset then 4 valid samples A=B=5 (defaults) -> `streak` 1,2,3,4; `lock_pulse` high one cycle after 4th edge; `locked`=1.
- LOCKED, then samples 3/4, 3/4, 3/3, 1/2, 1/2, 1/2 -> no unlock at the 2-miss gap; `unlock_pulse` one cycle after the 6th edge; `locked`=0.
- 20 consecutive matches with CNT_W=4 -> `streak` saturates at 15 and never wraps to 0.
- `in_valid`=0 for 10 cycles mid-streak at `streak`=2 -> all outputs hold. Next match -> `streak`=3.
- `clear` and `in_valid` asserted with a match while LOCKED -> SEARCH, `streak`=0, `eq_q`=0, no pulses.
- `rst_n` dropped asynchronously between edges while LOCKED -> all outputs 0 immediately. With `MATCH_LOCK_STATS_EN`, `match_total`/`miss_total` are also 0.
